// File: rtl/rv32_uart_tx_target.sv
// Memory-mapped 8N1 UART transmitter on the rv32 data bus: DATA/STATUS/DIV/IRQ_EN window feeding a TX FIFO.
// Optional interrupt support is built only when UART_TX_IRQ_EN is defined.
module rv32_uart_tx_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter logic [15:0] DEFAULT_DIV = 16'd104,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        tx_out,
  output logic        irq_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          sel, wr_en;
  logic [1:0]    off;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push_req, push_ok, pop, overflow;
  logic [15:0]   div, div_eff, bit_cnt;
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          unused_bits;

  assign sel      = data_address_in[31:4] == BASE_ADDR[31:4];
  assign off      = data_address_in[3:2];
  assign wr_en    = sel && data_write_in;
  assign full     = count == (AW+1)'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign push_req = wr_en && off == 2'd0 && data_write_mask_in[0];
  // Fullness is judged before the edge, so a same-cycle pop never makes room.
  assign push_ok  = push_req && !full;
  assign pop      = !empty && (state == IDLE || (state == STOP && bit_cnt == '0));
  assign div_eff  = (div == '0) ? 16'd1 : div;

  assign unused_bits = ^{data_address_in[1:0], data_write_mask_in[3:2], data_write_value_in[31:16]};

  // NOTE: FIFO storage has no reset; count and pointers alone say which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_write_value_in[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + (AW+1)'(1);
      else if (!push_ok && pop) count <= count - (AW+1)'(1);
      if (push_req && full)
        overflow <= 1'b1;
      else if (wr_en && off == 2'd1 && data_write_mask_in[0] && data_write_value_in[3])
        overflow <= 1'b0;
      if (wr_en && off == 2'd2) begin
        if (data_write_mask_in[0]) div[7:0]  <= data_write_value_in[7:0];
        if (data_write_mask_in[1]) div[15:8] <= data_write_value_in[15:8];
      end
    end
  end

  // Bit counter reloads from DIV at every bit boundary, so DIV changes land on the next bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      bit_cnt <= '0;
      tx_out  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            bit_cnt <= div_eff - 16'd1;
            tx_out  <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            tx_out  <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
            bit_cnt <= div_eff - 16'd1;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= div_eff - 16'd1;
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              tx_out  <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_cnt == '0) begin
            bit_cnt <= div_eff - 16'd1;
            if (pop) begin
              shreg  <= mem[rd_ptr];
              tx_out <= 1'b0;
              state  <= START;
            end else begin
              tx_out <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en, irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && off == 2'd3 && data_write_mask_in[0]) irq_en <= data_write_value_in[0];
      irq_q <= irq_en && empty && state == IDLE;
    end
  end

  assign irq_out = irq_q;
`else
  assign irq_out = 1'b0;
`endif

  always_comb begin
    data_read_value_out = '0;
    if (sel && data_read_in) begin
      case (off)
        2'd1: data_read_value_out = {16'h0, 8'(count), 4'h0, overflow, empty, full, state != IDLE};
        2'd2: data_read_value_out = {16'h0, div};
`ifdef UART_TX_IRQ_EN
        2'd3: data_read_value_out = {31'h0, irq_en};
`endif
        default: data_read_value_out = '0;
      endcase
    end
  end

endmodule
